// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register for the five-stage MIPS datapath with integrated
//   load-use hazard detection and a saturating stall-cycle counter.
//
// Ports
//   clk_i, rst_i       : rising-edge clock, async active-low reset
//   flush_i            : kill the ID instruction (taken branch/jump)
//   rsaddr_i/rtaddr_i/rdaddr_i, uses_rt_i : ID register addresses, rt-use flag
//   rsdata_i/rtdata_i/imm_i                : ID operands
//   regdst_i, alusrc_i, aluop_i            : EX controls
//   memread_i, memwrite_i                  : MEM controls
//   regwrite_i, memtoreg_i                 : WB controls
//   rsaddr_o/rtaddr_o/writeaddr_o          : registered addresses (to forwarding)
//   rsdata_o/rtdata_o/imm_o                : registered operands
//   ex_o {regdst,alusrc,aluop}, m_o {memread,memwrite}, wb_o {regwrite,memtoreg}
//   stall_o            : load-use hazard (combinational)
//   pcwrite_o, ifidwrite_o : ~stall_o (combinational)
//   stallcnt_o         : saturating count of stall cycles since reset
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [4:0]       rsaddr_i,
  input  logic [4:0]       rtaddr_i,
  input  logic [4:0]       rdaddr_i,
  input  logic             uses_rt_i,
  input  logic [31:0]      rsdata_i,
  input  logic [31:0]      rtdata_i,
  input  logic [31:0]      imm_i,
  input  logic             regdst_i,
  input  logic             alusrc_i,
  input  logic [1:0]       aluop_i,
  input  logic             memread_i,
  input  logic             memwrite_i,
  input  logic             regwrite_i,
  input  logic             memtoreg_i,
  output logic [4:0]       rsaddr_o,
  output logic [4:0]       rtaddr_o,
  output logic [4:0]       writeaddr_o,
  output logic [31:0]      rsdata_o,
  output logic [31:0]      rtdata_o,
  output logic [31:0]      imm_o,
  output logic [3:0]       ex_o,
  output logic [1:0]       m_o,
  output logic [1:0]       wb_o,
  output logic             stall_o,
  output logic             pcwrite_o,
  output logic             ifidwrite_o,
  output logic [CNT_W-1:0] stallcnt_o
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] r_rsaddr;
  logic [ADDR_W-1:0] r_rtaddr;
  logic [ADDR_W-1:0] r_writeaddr;
  logic [DATA_W-1:0] r_rsdata;
  logic [DATA_W-1:0] r_rtdata;
  logic [DATA_W-1:0] r_imm;
  logic [3:0]        r_ex;
  logic [1:0]        r_m;
  logic [1:0]        r_wb;
  logic [CNT_W-1:0]  r_stallcnt;

  logic w_rs_match;
  logic w_rt_match;
  logic w_hazard;
  logic w_stall;
  logic w_bubble;
  logic w_cnt_sat;
  logic [ADDR_W-1:0] w_writeaddr;

  // Load in EX whose destination is a source of the ID instruction; r0 never hazards.
  assign w_rs_match = (r_rtaddr == rsaddr_i);
  assign w_rt_match = uses_rt_i && (r_rtaddr == rtaddr_i);
  assign w_hazard   = r_m[1] && (r_rtaddr != ADDR_W'(0)) && (w_rs_match || w_rt_match);

  // A flushed instruction is discarded anyway, so it must not hold the front end.
  assign w_stall  = w_hazard && !flush_i;
  assign w_bubble = flush_i || w_stall;

  assign w_writeaddr = regdst_i ? rdaddr_i : rtaddr_i;
  assign w_cnt_sat   = &r_stallcnt;

  // Pipeline register: bubble zeroes everything, including addresses, so
  // the forwarding unit sees r0 and cannot match.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rsaddr    <= '0;
      r_rtaddr    <= '0;
      r_writeaddr <= '0;
      r_rsdata    <= '0;
      r_rtdata    <= '0;
      r_imm       <= '0;
      r_ex        <= '0;
      r_m         <= '0;
      r_wb        <= '0;
    end else if (w_bubble) begin
      r_rsaddr    <= '0;
      r_rtaddr    <= '0;
      r_writeaddr <= '0;
      r_rsdata    <= '0;
      r_rtdata    <= '0;
      r_imm       <= '0;
      r_ex        <= '0;
      r_m         <= '0;
      r_wb        <= '0;
    end else begin
      r_rsaddr    <= rsaddr_i;
      r_rtaddr    <= rtaddr_i;
      r_writeaddr <= w_writeaddr;
      r_rsdata    <= rsdata_i;
      r_rtdata    <= rtdata_i;
      r_imm       <= imm_i;
      r_ex        <= {regdst_i, alusrc_i, aluop_i};
      r_m         <= {memread_i, memwrite_i};
      r_wb        <= {regwrite_i, memtoreg_i};
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stallcnt <= '0;
    end else if (w_stall && !w_cnt_sat) begin
      r_stallcnt <= r_stallcnt + CNT_W'(1);
    end
  end

  assign rsaddr_o    = r_rsaddr;
  assign rtaddr_o    = r_rtaddr;
  assign writeaddr_o = r_writeaddr;
  assign rsdata_o    = r_rsdata;
  assign rtdata_o    = r_rtdata;
  assign imm_o       = r_imm;
  assign ex_o        = r_ex;
  assign m_o         = r_m;
  assign wb_o        = r_wb;
  assign stall_o     = w_stall;
  assign pcwrite_o   = ~w_stall;
  assign ifidwrite_o = ~w_stall;
  assign stallcnt_o  = r_stallcnt;

endmodule
